// File: rtl/phy_reset_seq.sv
// -----------------------------------------------------------------------------
// phy_reset_seq
//   Multi-channel PHY power-on / software reset sequencer. Each channel holds
//   its active-low PHY reset pin low for an assert window, then waits a settle
//   window before flagging ready. On power-on, channel i's assert window is
//   stretched by i*STAGGER_CYCLES so the PHYs leave reset one after another
//   rather than all drawing inrush current together. A software request
//   (re)starts a channel with a plain ASSERT_CYCLES window. Channels share no
//   state with each other.
//
// Optional build macro: PHY_RST_WDOG_EN
//   Adds WDOG_CYCLES, phy_alive and wdog_fired. While a channel is READY, a
//   phy_alive gap of WDOG_CYCLES cycles re-resets that channel exactly as a
//   software request would, and sets its sticky wdog_fired flag.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sw_rst_req   per-channel reset request (synchronous, level)
//   phy_alive    per-channel heartbeat, pre-synchronised (watchdog build only)
//   phy_resetn   per-channel active-low PHY reset pin (registered)
//   phy_ready    per-channel out-of-reset-and-settled flag (registered)
//   wdog_fired   per-channel sticky watchdog flag (watchdog build only)
//   busy         high while any channel is not ready
// -----------------------------------------------------------------------------
module phy_reset_seq #(
`ifdef PHY_RST_WDOG_EN
    parameter int WDOG_CYCLES    = 25000000,
`endif
    parameter int NUM_PHY        = 2,
    parameter int ASSERT_CYCLES  = 500000,
    parameter int SETTLE_CYCLES  = 250000,
    parameter int STAGGER_CYCLES = 50000,
    parameter int CNT_W          = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_PHY-1:0] sw_rst_req,
`ifdef PHY_RST_WDOG_EN
    input  logic [NUM_PHY-1:0] phy_alive,
    output logic [NUM_PHY-1:0] wdog_fired,
`endif
    output logic [NUM_PHY-1:0] phy_resetn,
    output logic [NUM_PHY-1:0] phy_ready,
    output logic               busy
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (longint'(ASSERT_CYCLES) + longint'(NUM_PHY - 1) * longint'(STAGGER_CYCLES) > CNT_MAX ||
        longint'(SETTLE_CYCLES) > CNT_MAX) begin : g_cnt_w_err
        $error("phy_reset_seq: CNT_W=%0d too narrow for the configured windows", CNT_W);
    end
    if (NUM_PHY < 1 || ASSERT_CYCLES < 1 || SETTLE_CYCLES < 1 || STAGGER_CYCLES < 0) begin : g_param_err
        $error("phy_reset_seq: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] SW_LEN_M1  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_M1  = CNT_W'(SETTLE_CYCLES - 1);

`ifdef PHY_RST_WDOG_EN
    localparam int               WD_W      = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LIM    = WD_W'(WDOG_CYCLES - 1);
`endif

    for (genvar g = 0; g < NUM_PHY; g++) begin : g_ch
        // Power-on window includes this channel's stagger slot.
        localparam logic [CNT_W-1:0] PWR_LEN_M1 = CNT_W'(ASSERT_CYCLES + g * STAGGER_CYCLES - 1);

        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pwr_q, pwr_d;
        logic             resetn_q, resetn_d;
        logic             ready_q, ready_d;
        logic             rst_req;

`ifdef PHY_RST_WDOG_EN
        logic [WD_W-1:0]  wcnt_q, wcnt_d;
        logic             fired_q, fired_d;
        logic             wd_trip;

        assign wd_trip = (state_q == ST_READY) && !phy_alive[g] && (wcnt_q == WD_LIM);
        assign rst_req = sw_rst_req[g] | wd_trip;

        always_comb begin
            fired_d = fired_q | wd_trip;
            wcnt_d  = '0;
            // Counts consecutive dead cycles only while settled in READY.
            if (state_q == ST_READY && !rst_req && !phy_alive[g])
                wcnt_d = wcnt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wcnt_q  <= '0;
                fired_q <= 1'b0;
            end else begin
                wcnt_q  <= wcnt_d;
                fired_q <= fired_d;
            end
        end

        assign wdog_fired[g] = fired_q;
`else
        assign rst_req = sw_rst_req[g];
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pwr_d   = pwr_q;
            if (rst_req) begin
                // Restart from any state; a held request pins cnt at 0.
                state_d = ST_ASSERT;
                cnt_d   = '0;
                pwr_d   = 1'b0;
            end else begin
                unique case (state_q)
                    ST_ASSERT: begin
                        if (cnt_q == (pwr_q ? PWR_LEN_M1 : SW_LEN_M1)) begin
                            state_d = ST_SETTLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == SETTLE_M1) begin
                            state_d = ST_READY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_READY:  cnt_d = '0;
                    default: begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                    end
                endcase
            end
            // Pins decode the next state so they move on the same edge.
            resetn_d = (state_d != ST_ASSERT);
            ready_d  = (state_d == ST_READY);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= ST_ASSERT;
                cnt_q    <= '0;
                pwr_q    <= 1'b1;
                resetn_q <= 1'b0;
                ready_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                pwr_q    <= pwr_d;
                resetn_q <= resetn_d;
                ready_q  <= ready_d;
            end
        end

        assign phy_resetn[g] = resetn_q;
        assign phy_ready[g]  = ready_q;
    end

    assign busy = |(~phy_ready);

endmodule

// File: doc/phy_reset_seq.md
Name: phy_reset_seq

Overview:
- Parametrised multi-channel successor to the single-PHY power-on reset counter.
- Drives NUM_PHY independent active-low PHY reset pins with configurable assert and settle times.
- Staggers power-on releases so PHYs do not draw inrush together, and accepts per-channel software reset requests.
- Reports a per-channel ready flag for the MAC/MDIO logic. Sits at the top of the Ethernet core beside the PLL/reset bridge.

Parameters:
- NUM_PHY, 2, number of PHY channels (≥1).
- ASSERT_CYCLES, 500000, reset-low time in clk cycles (10 ms at 50 MHz), ≥1.
- SETTLE_CYCLES, 250000, cycles from reset release to phy_ready (PHY strap/PLL settle), ≥1.
- STAGGER_CYCLES, 50000, extra power-on assert time per channel index; 0 disables stagger.
- CNT_W, 24, per-channel counter width. Must hold ASSERT_CYCLES+(NUM_PHY-1)*STAGGER_CYCLES and SETTLE_CYCLES. Violation is a $error at elaboration.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- sw_rst_req  input  NUM_PHY  per-channel reset request, sampled on clk, synchronous.
- phy_resetn  output  NUM_PHY  active-low PHY reset pins, registered.
- phy_ready  output  NUM_PHY  channel out of reset and settled, registered.
- busy  output  1  OR of ~phy_ready.

Behaviour:
- Reset domain: reset_n asynchronous, active-low; clock clk.
- Reset values while reset_n=0: phy_resetn=0, phy_ready=0, busy=1, all channels in ASSERT, counters=0, power-on flag=1.
- Per-channel FSM with states ASSERT, SETTLE, READY and counter cnt_i. There is no shared state between channels.
- ASSERT length for channel i:
  - LEN_i = ASSERT_CYCLES + i*STAGGER_CYCLES when entered from power-on.
  - LEN_i = ASSERT_CYCLES when entered by sw_rst_req (no stagger).
- ASSERT state:
  - phy_resetn[i]=0, phy_ready[i]=0.
  - cnt increments each edge. When cnt==LEN_i-1, go to SETTLE and clear cnt.
  - Result: phy_resetn[i] rises on the LEN_i-th clk edge after reset_n deassert, so it is low for exactly LEN_i full cycles.
- SETTLE state:
  - phy_resetn[i]=1, phy_ready[i]=0.
  - When cnt==SETTLE_CYCLES-1, go to READY.
  - phy_ready[i] rises exactly SETTLE_CYCLES edges after phy_resetn[i] rises.
- READY state: phy_resetn[i]=1, phy_ready[i]=1. Hold until sw_rst_req[i].
- sw_rst_req[i]=1 at an edge, in any state:
  - Enter ASSERT with cnt=0 and clear the power-on flag for i.
  - phy_resetn[i] and phy_ready[i] fall in the same edge's registered update.
- Request arriving mid-ASSERT or mid-SETTLE restarts the full ASSERT_CYCLES window. A mid-power-on request therefore drops that channel's stagger.
- sw_rst_req held high: the channel stays in ASSERT, with cnt held at 0 each cycle. The ASSERT_CYCLES count starts on the first edge sampling it low.
- Simultaneous requests on several channels are independent, with no arbitration.
- reset_n asserted mid-operation: all channels immediately (asynchronously) return to reset values, and power-on stagger applies again on release.
- busy is combinational OR of registered ~phy_ready, so it carries no extra latency.
- Counter compares are equality on CNT_W bits; the counter never wraps in legal configs.

Optional Feature:
- Macro: PHY_RST_WDOG_EN.
- With the macro:
  - Adds parameter WDOG_CYCLES (default 25000000).
  - Adds input phy_alive[NUM_PHY] (e.g. link/MDIO heartbeat, pre-synchronised).
  - Adds output wdog_fired[NUM_PHY], sticky, cleared only by reset_n.
  - In READY, a per-channel watchdog counter counts while phy_alive[i]=0 and clears when phy_alive[i]=1.
  - On reaching WDOG_CYCLES-1, the channel behaves exactly as if sw_rst_req[i] had been sampled, and wdog_fired[i] sets.
  - The watchdog counter is held at 0 outside READY.
- Without the macro: those ports and parameter are absent and there is no autonomous re-reset.

Test Plan (NUM_PHY=3, ASSERT_CYCLES=8, SETTLE_CYCLES=4, STAGGER_CYCLES=3, CNT_W=8):
- Power-on: release reset_n → phy_resetn[0,1,2] rise at edges 8, 11, 14; phy_ready at 12, 15, 18; busy falls at edge 18.
- SW reset from READY: 1-cycle sw_rst_req[1] → phy_resetn[1], phy_ready[1] low the next cycle; resetn high after 8 edges, ready 4 later; channels 0 and 2 undisturbed.
- Held request: sw_rst_req[0] high 20 cycles → phy_resetn[0] low throughout, rising 8 edges after the request drops.
- Restart mid-SETTLE: request on channel 2 two edges into SETTLE → ASSERT restarts with 8 cycles, no stagger; ready 12 edges after the request.
- Async reset mid-operation: pull reset_n low while all READY → all outputs 0 and busy=1 immediately; release replays the 8/11/14 stagger.
- With PHY_RST_WDOG_EN and WDOG_CYCLES=10: phy_alive[0]=0 for 10 cycles in READY → channel 0 re-resets and wdog_fired[0]=1 stays set. A 9-cycle gap followed by a high cycle causes no action.
